// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage in-order core.
// Tracks EX/MM/WB occupancy, stalls on memory wait and load-use, flushes on redirect, registers forwarding selects.
module pipeline_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_valid,
    output logic                  if_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_mm_re,
    input  logic                  id_mm_we,
    input  logic                  ex_redirect,
    input  logic                  mm_ready,
    output logic                  id_en,
    output logic                  ex_en,
    output logic                  mm_en,
    output logic                  ex_valid,
    output logic                  mm_valid,
    output logic                  wb_valid,
    output logic                  pc_redirect,
    output logic                  flush_id,
    output logic                  stall_load_use,
    output logic [1:0]            fwd_rs1_sel,
    output logic [1:0]            fwd_rs2_sel
);

    logic                  v_ex, v_mm, v_wb;
    logic [REG_ADDR_W-1:0] rd_ex, rd_mm, rd_wb;
    logic                  ld_ex, mem_ex, mem_mm;

    logic rs1_ex, rs2_ex, rs1_mm, rs2_mm, rs1_wb, rs2_wb;
    logic raw_ex, raw_mm, raw_wb;
    logic mm_stall, redir, load_use;
    logic [1:0] nxt_rs1_sel, nxt_rs2_sel;

    // x0 never carries a dependency, and an empty stage never produces one
    function automatic logic hit(input logic v, input logic [REG_ADDR_W-1:0] rd,
                                 input logic [REG_ADDR_W-1:0] src);
        return v && (rd != '0) && (rd == src);
    endfunction

    always_comb begin
        rs1_ex = if_valid & hit(v_ex, rd_ex, id_rs1_addr);
        rs2_ex = if_valid & hit(v_ex, rd_ex, id_rs2_addr);
        rs1_mm = if_valid & hit(v_mm, rd_mm, id_rs1_addr);
        rs2_mm = if_valid & hit(v_mm, rd_mm, id_rs2_addr);
        rs1_wb = if_valid & hit(v_wb, rd_wb, id_rs1_addr);
        rs2_wb = if_valid & hit(v_wb, rd_wb, id_rs2_addr);
        raw_ex = rs1_ex | rs2_ex;
        raw_mm = rs1_mm | rs2_mm;
        raw_wb = rs1_wb | rs2_wb;

        mm_stall = v_mm & mem_mm & ~mm_ready;
        redir    = v_ex & ex_redirect;
        load_use = FWD_EN ? (ld_ex & raw_ex) : (raw_ex | raw_mm | raw_wb);

        nxt_rs1_sel = 2'b00;
        nxt_rs2_sel = 2'b00;
        if (FWD_EN) begin
            if (rs1_ex)      nxt_rs1_sel = 2'b01;
            else if (rs1_mm) nxt_rs1_sel = 2'b10;
            if (rs2_ex)      nxt_rs2_sel = 2'b01;
            else if (rs2_mm) nxt_rs2_sel = 2'b10;
        end
    end

    always_comb begin
        if_ready       = 1'b1;
        id_en          = 1'b1;
        ex_en          = 1'b1;
        mm_en          = 1'b1;
        pc_redirect    = 1'b0;
        flush_id       = 1'b0;
        stall_load_use = 1'b0;
        if (mm_stall) begin
            if_ready = 1'b0;
            id_en    = 1'b0;
            ex_en    = 1'b0;
            mm_en    = 1'b0;
        end else if (redir) begin
            pc_redirect = 1'b1;
            flush_id    = 1'b1;
        end else if (load_use) begin
            if_ready       = 1'b0;
            id_en          = 1'b0;
            stall_load_use = 1'b1;
        end
    end

    // A memory wait freezes every stage; a redirect or load-use turns the EX slot into a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_ex        <= 1'b0;
            v_mm        <= 1'b0;
            v_wb        <= 1'b0;
            rd_ex       <= '0;
            rd_mm       <= '0;
            rd_wb       <= '0;
            ld_ex       <= 1'b0;
            mem_ex      <= 1'b0;
            mem_mm      <= 1'b0;
            fwd_rs1_sel <= 2'b00;
            fwd_rs2_sel <= 2'b00;
        end else if (!mm_stall) begin
            v_mm   <= v_ex;
            rd_mm  <= rd_ex;
            mem_mm <= mem_ex;
            v_wb   <= v_mm;
            rd_wb  <= rd_mm;
            if (redir || load_use) begin
                v_ex        <= 1'b0;
                rd_ex       <= '0;
                ld_ex       <= 1'b0;
                mem_ex      <= 1'b0;
                fwd_rs1_sel <= 2'b00;
                fwd_rs2_sel <= 2'b00;
            end else begin
                v_ex        <= if_valid;
                rd_ex       <= if_valid ? id_rd_addr : '0;
                ld_ex       <= if_valid & id_mm_re;
                mem_ex      <= if_valid & (id_mm_re | id_mm_we);
                fwd_rs1_sel <= nxt_rs1_sel;
                fwd_rs2_sel <= nxt_rs2_sel;
            end
        end
    end

    assign ex_valid = v_ex;
    assign mm_valid = v_mm;
    assign wb_valid = v_wb;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one instance with forwarding, one without.
// Each step drives the ID slot after a rising edge and compares all outputs at the falling edge.
module tb_pipeline_ctrl;

    logic       clk;
    logic       reset;
    logic       if_valid;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic       id_mm_re, id_mm_we, ex_redirect, mm_ready;

    logic       if_ready_f, id_en_f, ex_en_f, mm_en_f, ex_valid_f, mm_valid_f, wb_valid_f;
    logic       pc_redirect_f, flush_id_f, stall_f;
    logic [1:0] fwd1_f, fwd2_f;
    logic       if_ready_n, id_en_n, ex_en_n, mm_en_n, ex_valid_n, mm_valid_n, wb_valid_n;
    logic       pc_redirect_n, flush_id_n, stall_n;
    logic [1:0] fwd1_n, fwd2_n;

    int num_checks = 0;
    int num_fail   = 0;

    // Expected word: {if_ready,id_en,ex_en,mm_en, ex/mm/wb valid, pc_redirect,flush_id,stall_load_use, fwd1, fwd2}
    localparam logic [3:0] EN_ALL   = 4'b1111;
    localparam logic [3:0] EN_STALL = 4'b0000;
    localparam logic [3:0] EN_LU    = 4'b0011;
    localparam logic [2:0] C_NONE   = 3'b000;
    localparam logic [2:0] C_REDIR  = 3'b110;
    localparam logic [2:0] C_LU     = 3'b001;

    typedef struct {
        string       name;
        logic        iv;
        logic [4:0]  rs1, rs2, rd;
        logic        re, we, redir, rdy;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    pipeline_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b1)) u_dut_fwd (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready_f),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_mm_re(id_mm_re), .id_mm_we(id_mm_we), .ex_redirect(ex_redirect), .mm_ready(mm_ready),
        .id_en(id_en_f), .ex_en(ex_en_f), .mm_en(mm_en_f),
        .ex_valid(ex_valid_f), .mm_valid(mm_valid_f), .wb_valid(wb_valid_f),
        .pc_redirect(pc_redirect_f), .flush_id(flush_id_f), .stall_load_use(stall_f),
        .fwd_rs1_sel(fwd1_f), .fwd_rs2_sel(fwd2_f)
    );

    pipeline_ctrl #(.REG_ADDR_W(5), .FWD_EN(1'b0)) u_dut_nf (
        .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_mm_re(id_mm_re), .id_mm_we(id_mm_we), .ex_redirect(ex_redirect), .mm_ready(mm_ready),
        .id_en(id_en_n), .ex_en(ex_en_n), .mm_en(mm_en_n),
        .ex_valid(ex_valid_n), .mm_valid(mm_valid_n), .wb_valid(wb_valid_n),
        .pc_redirect(pc_redirect_n), .flush_id(flush_id_n), .stall_load_use(stall_n),
        .fwd_rs1_sel(fwd1_n), .fwd_rs2_sel(fwd2_n)
    );

    logic [13:0] act_f, act_n;
    assign act_f = {if_ready_f, id_en_f, ex_en_f, mm_en_f, ex_valid_f, mm_valid_f, wb_valid_f,
                    pc_redirect_f, flush_id_f, stall_f, fwd1_f, fwd2_f};
    assign act_n = {if_ready_n, id_en_n, ex_en_n, mm_en_n, ex_valid_n, mm_valid_n, wb_valid_n,
                    pc_redirect_n, flush_id_n, stall_n, fwd1_n, fwd2_n};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input string name, input logic iv, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd, input logic re,
                                input logic we, input logic redir, input logic rdy,
                                input logic [3:0] en, input logic [2:0] v, input logic [2:0] ctl,
                                input logic [1:0] f1, input logic [1:0] f2);
        vec_t t;
        t.name = name; t.iv = iv; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.re = re; t.we = we; t.redir = redir; t.rdy = rdy;
        t.exp = {en, v, ctl, f1, f2};
        return t;
    endfunction

    task automatic applyStimulus(input vec_t t);
        @(posedge clk);
        #1;
        if_valid    = t.iv;
        id_rs1_addr = t.rs1;
        id_rs2_addr = t.rs2;
        id_rd_addr  = t.rd;
        id_mm_re    = t.re;
        id_mm_we    = t.we;
        ex_redirect = t.redir;
        mm_ready    = t.rdy;
    endtask

    task automatic checkOutput(input string name, input bit use_nf, input logic [13:0] exp);
        logic [13:0] act;
        act = use_nf ? act_n : act_f;
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s (%s): actual=%b required=%b", name,
                     use_nf ? "no-fwd" : "fwd", act, exp);
        end
    endtask

    task automatic step(input vec_t t, input bit use_nf);
        applyStimulus(t);
        @(negedge clk);
        checkOutput(t.name, use_nf, t.exp);
    endtask

    task automatic set_idle();
        if_valid = 1'b0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
        id_mm_re = 1'b0; id_mm_we = 1'b0; ex_redirect = 1'b0; mm_ready = 1'b1;
    endtask

    task automatic doReset();
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", 1'b0, {EN_ALL, 3'b000, C_NONE, 2'b00, 2'b00});
        checkOutput("reset_state", 1'b1, {EN_ALL, 3'b000, C_NONE, 2'b00, 2'b00});
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        set_idle();
        $display("[TB] pipeline_ctrl directed test start");

        // Forwarding stream: independent ALU ops, EX/MM forwarding, load-use, x0, idle slots
        vecs.push_back(mk("alu0",        1'b1, 5'd10, 5'd11, 5'd1,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b000, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("alu1",        1'b1, 5'd12, 5'd13, 5'd2,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b100, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("alu2",        1'b1, 5'd14, 5'd15, 5'd3,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b110, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("alu3",        1'b1, 5'd16, 5'd17, 5'd4,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b111, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("add_x5",      1'b1, 5'd18, 5'd19, 5'd5,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b111, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("sub_x6_x5",   1'b1, 5'd5,  5'd1,  5'd6,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b111, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("fwd_from_mm", 1'b1, 5'd20, 5'd21, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b111, C_NONE, 2'b01, 2'b00));
        vecs.push_back(mk("indep_gap",   1'b1, 5'd22, 5'd23, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b111, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("sub_x13_x11", 1'b1, 5'd11, 5'd1,  5'd13, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b111, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("lw_x7",       1'b1, 5'd24, 5'd25, 5'd7,  1'b1, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b111, C_NONE, 2'b10, 2'b00));
        vecs.push_back(mk("load_use",    1'b1, 5'd7,  5'd7,  5'd8,  1'b0, 1'b0, 1'b0, 1'b1, EN_LU,  3'b111, C_LU,   2'b00, 2'b00));
        vecs.push_back(mk("after_bubble",1'b1, 5'd7,  5'd7,  5'd8,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b011, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("fwd_from_wb", 1'b1, 5'd26, 5'd27, 5'd14, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b101, C_NONE, 2'b10, 2'b10));
        vecs.push_back(mk("lw_x0",       1'b1, 5'd28, 5'd29, 5'd0,  1'b1, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b110, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("read_x0",     1'b1, 5'd0,  5'd0,  5'd15, 1'b1, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b111, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("idle_slot",   1'b0, 5'd15, 5'd15, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b111, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("drain1",      1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b011, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("drain2",      1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b001, C_NONE, 2'b00, 2'b00));
        vecs.push_back(mk("drain3",      1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b000, C_NONE, 2'b00, 2'b00));

        doReset();
        for (int i = 0; i < vecs.size(); i++) step(vecs[i], 1'b0);

        // Load waits 3 cycles in MM while a JAL behind it requests a redirect
        doReset();
        step(mk("t4_lw",       1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, EN_ALL,   3'b000, C_NONE,  2'b00, 2'b00), 1'b0);
        step(mk("t4_jal",      1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL,   3'b100, C_NONE,  2'b00, 2'b00), 1'b0);
        for (int i = 0; i < 3; i++)
            step(mk("t4_mm_stall", 1'b1, 5'd4, 5'd5, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, EN_STALL, 3'b110, C_NONE, 2'b00, 2'b00), 1'b0);
        step(mk("t4_redirect", 1'b1, 5'd4, 5'd5, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1, EN_ALL,   3'b110, C_REDIR, 2'b00, 2'b00), 1'b0);
        step(mk("t4_after",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, EN_ALL,   3'b011, C_NONE,  2'b00, 2'b00), 1'b0);
        step(mk("t4_drain",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL,   3'b001, C_NONE,  2'b00, 2'b00), 1'b0);

        // Store stalls MM with a redirect pending, then reset discards both
        doReset();
        step(mk("rr_store",    1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, EN_ALL,   3'b000, C_NONE, 2'b00, 2'b00), 1'b0);
        step(mk("rr_jal",      1'b1, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL,   3'b100, C_NONE, 2'b00, 2'b00), 1'b0);
        step(mk("rr_mm_stall", 1'b1, 5'd4, 5'd5, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, EN_STALL, 3'b110, C_NONE, 2'b00, 2'b00), 1'b0);
        #1 reset = 1'b1;
        #1 checkOutput("rr_reset_clears", 1'b0, {EN_ALL, 3'b000, C_NONE, 2'b00, 2'b00});
        if_valid = 1'b0; mm_ready = 1'b1; ex_redirect = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        step(mk("rr_no_redirect", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, EN_ALL, 3'b000, C_NONE, 2'b00, 2'b00), 1'b0);

        // No forwarding: RAW on x3 stalls until the producer leaves WB
        doReset();
        step(mk("t6_add_x3",  1'b1, 5'd10, 5'd11, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b000, C_NONE, 2'b00, 2'b00), 1'b1);
        step(mk("t6_raw_ex",  1'b1, 5'd3,  5'd2,  5'd4, 1'b0, 1'b0, 1'b0, 1'b1, EN_LU,  3'b100, C_LU,   2'b00, 2'b00), 1'b1);
        step(mk("t6_raw_mm",  1'b1, 5'd3,  5'd2,  5'd4, 1'b0, 1'b0, 1'b0, 1'b1, EN_LU,  3'b010, C_LU,   2'b00, 2'b00), 1'b1);
        step(mk("t6_raw_wb",  1'b1, 5'd3,  5'd2,  5'd4, 1'b0, 1'b0, 1'b0, 1'b1, EN_LU,  3'b001, C_LU,   2'b00, 2'b00), 1'b1);
        step(mk("t6_release", 1'b1, 5'd3,  5'd2,  5'd4, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b000, C_NONE, 2'b00, 2'b00), 1'b1);
        step(mk("t6_or_in_ex",1'b0, 5'd0,  5'd0,  5'd0, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b100, C_NONE, 2'b00, 2'b00), 1'b1);
        step(mk("t6b_add_x3", 1'b1, 5'd10, 5'd11, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, EN_ALL, 3'b010, C_NONE, 2'b00, 2'b00), 1'b1);
        step(mk("t6b_raw",    1'b1, 5'd3,  5'd2,  5'd4, 1'b0, 1'b0, 1'b0, 1'b1, EN_LU,  3'b101, C_LU,   2'b00, 2'b00), 1'b1);
        #1 reset = 1'b1;
        #1 checkOutput("t6b_reset_mid_stall", 1'b1, {EN_ALL, 3'b000, C_NONE, 2'b00, 2'b00});
        set_idle();
        @(posedge clk);
        #1 reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
